// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and defaults for the CORDIC engine arbiter
package cordic_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_BUSY    = 3'd2,
        ST_RESP    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    typedef logic req_idx_t;

    function automatic logic [1:0] idx_onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cordic_arbiter_if.sv
// rtl/cordic_arbiter_if.sv - two-requester request/response bundle for the CORDIC arbiter
interface cordic_arbiter_if
    import cordic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_mode;
    logic [2*DATA_W-1:0] req_x;
    logic [2*DATA_W-1:0] req_y;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_x;
    logic [DATA_W-1:0]   rsp_y;
    logic                rsp_err;

    modport slave (
        input  req_valid, req_mode, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_x, rsp_y, rsp_err
    );

    modport master (
        output req_valid, req_mode, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_x, rsp_y, rsp_err
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker; on contention the side not granted last wins
module rr_arb2
    import cordic_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = idx_onehot(~last);
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - shares one CORDIC engine between two requesters with watchdog recovery
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 63,
    parameter int RST_CYC     = 2
) (
    input  logic              clka,
    input  logic              reset_n,
    cordic_arbiter_if.slave   cli,
    output logic              eng_start,
    output logic              eng_mode,
    output logic [DATA_W-1:0] eng_port0,
    output logic [DATA_W-1:0] eng_port1,
    output logic              eng_reset,
    input  logic [DATA_W-1:0] eng_out0,
    input  logic [DATA_W-1:0] eng_out1,
    input  logic              eng_done,
    output logic              busy
);
    localparam int CNT_MAX = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state, state_nxt;
    req_idx_t          last_grant, grant_idx;
    logic [1:0]        gnt;
    logic [CNT_W-1:0]  cnt;
    logic              op_mode;
    logic [DATA_W-1:0] op_x, op_y, res_x, res_y;
    logic              res_err;
    logic              timeout, rst_done;

    rr_arb2 u_arb (
        .req  (cli.req_valid),
        .last (last_grant),
        .gnt  (gnt)
    );

    assign timeout  = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign rst_done = (cnt == CNT_W'(RST_CYC - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (gnt != 2'b00) state_nxt = ST_START;
            ST_START:   state_nxt = ST_BUSY;
            // done beats a coincident timeout
            ST_BUSY:    if (eng_done) state_nxt = ST_RESP;
                        else if (timeout) state_nxt = ST_RECOVER;
            ST_RECOVER: if (rst_done) state_nxt = ST_RESP;
            ST_RESP:    if (cli.rsp_ready[grant_idx]) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // cnt restarts at 0 on every state change: watchdog in BUSY, pulse length in RECOVER
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            grant_idx  <= 1'b0;
            op_mode    <= 1'b0;
            op_x       <= '0;
            op_y       <= '0;
            res_x      <= '0;
            res_y      <= '0;
            res_err    <= 1'b0;
        end else begin
            if (state == ST_IDLE && gnt != 2'b00) begin
                grant_idx  <= gnt[1];
                last_grant <= gnt[1];
                op_mode    <= cli.req_mode[gnt[1]];
                op_x       <= gnt[1] ? cli.req_x[2*DATA_W-1:DATA_W] : cli.req_x[DATA_W-1:0];
                op_y       <= gnt[1] ? cli.req_y[2*DATA_W-1:DATA_W] : cli.req_y[DATA_W-1:0];
            end
            if (state == ST_BUSY) begin
                if (eng_done) begin
                    res_x   <= eng_out0;
                    res_y   <= eng_out1;
                    res_err <= 1'b0;
                end else if (timeout) begin
                    res_x   <= '0;
                    res_y   <= '0;
                    res_err <= 1'b1;
                end
            end
        end
    end

    assign cli.req_ready = (state == ST_IDLE && reset_n) ? gnt : 2'b00;
    assign cli.rsp_valid = (state == ST_RESP) ? idx_onehot(grant_idx) : 2'b00;
    assign cli.rsp_x     = res_x;
    assign cli.rsp_y     = res_y;
    assign cli.rsp_err   = res_err;
    assign eng_start     = (state == ST_START);
    assign eng_reset     = (state == ST_RECOVER);
    assign eng_mode      = op_mode;
    assign eng_port0     = op_x;
    assign eng_port1     = op_y;
    assign busy          = (state != ST_IDLE);
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - randomized self-checking bench for cordic_arbiter
module tb_cordic_arbiter;
    import cordic_pkg::*;

    localparam int DW = 8;
    localparam int TO = 63;
    localparam int RC = 2;

    logic          clka = 1'b0;
    logic          reset_n = 1'b0;
    logic          eng_start, eng_mode, eng_reset, busy;
    logic          eng_done = 1'b0;
    logic [DW-1:0] eng_port0, eng_port1;
    logic [DW-1:0] eng_out0 = '0, eng_out1 = '0;

    cordic_arbiter_if #(.DATA_W(DW)) cli ();

    cordic_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TO), .RST_CYC(RC)) dut (
        .clka      (clka),
        .reset_n   (reset_n),
        .cli       (cli),
        .eng_start (eng_start),
        .eng_mode  (eng_mode),
        .eng_port0 (eng_port0),
        .eng_port1 (eng_port1),
        .eng_reset (eng_reset),
        .eng_out0  (eng_out0),
        .eng_out1  (eng_out1),
        .eng_done  (eng_done),
        .busy      (busy)
    );

    always #5 clka = ~clka;

    int n_tests = 0;
    int n_fail  = 0;
    int last_grant_m = 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // lat < 0 means the engine hangs; early raises eng_done during the start cycle
    task automatic run_job(input logic [1:0] mask, input int lat, input bit early, input int hold,
                           input bit fixed, input logic [DW-1:0] fx, input logic [DW-1:0] fo0,
                           input logic [DW-1:0] fo1);
        logic [DW-1:0] x [2];
        logic [DW-1:0] y [2];
        logic          m [2];
        logic [DW-1:0] o0, o1, ex, ey;
        int            w, starts, resets, rsp_at, exp_at;
        bit            hang;
        hang = (lat < 0);
        for (int i = 0; i < 2; i++) begin
            x[i] = DW'($urandom);
            y[i] = DW'($urandom);
            m[i] = 1'($urandom);
        end
        o0 = DW'($urandom);
        o1 = DW'($urandom);
        if (fixed) begin
            x[0] = fx; y[0] = '0; m[0] = 1'b0; o0 = fo0; o1 = fo1;
        end
        w = (mask == 2'b11) ? 1 - last_grant_m : (mask[1] ? 1 : 0);
        cli.req_valid = mask;
        cli.req_mode  = {m[1], m[0]};
        cli.req_x     = {x[1], x[0]};
        cli.req_y     = {y[1], y[0]};
        #1;
        for (int k = 0; k < 4 && cli.req_ready == 2'b00; k++) @(negedge clka);
        check_val("req_ready_winner", 32'(cli.req_ready), 32'(1 << w));
        @(posedge clka);
        last_grant_m = w;
        @(negedge clka);
        check_val("eng_start", 32'(eng_start), 1);
        check_val("eng_port0", 32'(eng_port0), 32'(x[w]));
        check_val("eng_port1", 32'(eng_port1), 32'(y[w]));
        check_val("eng_mode", 32'(eng_mode), 32'(m[w]));
        check_val("req_ready_start", 32'(cli.req_ready), 0);
        eng_done = early;
        eng_out0 = DW'($urandom);
        eng_out1 = DW'($urandom);
        starts = 0; resets = 0; rsp_at = -1;
        for (int cyc = 1; cyc <= TO + RC + 8 && rsp_at < 0; cyc++) begin
            @(negedge clka);
            eng_done = 1'b0;
            eng_out0 = DW'($urandom);
            eng_out1 = DW'($urandom);
            if (cli.rsp_valid != 2'b00) rsp_at = cyc;
            else begin
                starts += int'(eng_start);
                resets += int'(eng_reset);
                if (!hang && cyc == lat + 1) begin
                    eng_done = 1'b1; eng_out0 = o0; eng_out1 = o1;
                end
            end
        end
        exp_at = hang ? TO + RC + 1 : lat + 2;
        ex = hang ? '0 : o0;
        ey = hang ? '0 : o1;
        check_val("rsp_latency", 32'(rsp_at), 32'(exp_at));
        check_val("extra_starts", 32'(starts), 0);
        check_val("eng_reset_cycles", 32'(resets), hang ? 32'(RC) : 0);
        check_val("rsp_valid_bit", 32'(cli.rsp_valid), 32'(1 << w));
        check_val("rsp_x", 32'(cli.rsp_x), 32'(ex));
        check_val("rsp_y", 32'(cli.rsp_y), 32'(ey));
        check_val("rsp_err", 32'(cli.rsp_err), 32'(hang));
        for (int k = 0; k < hold; k++) begin
            cli.rsp_ready = 2'(1 << (1 - w)) & 2'($urandom);
            cli.req_valid = 2'($urandom);
            #1;
            check_val("hold_req_ready", 32'(cli.req_ready), 0);
            @(negedge clka);
            check_val("hold_rsp_valid", 32'(cli.rsp_valid), 32'(1 << w));
            check_val("hold_rsp_x", 32'(cli.rsp_x), 32'(ex));
            check_val("hold_rsp_err", 32'(cli.rsp_err), 32'(hang));
            check_val("hold_busy", 32'(busy), 1);
        end
        cli.req_valid = 2'b00;
        cli.rsp_ready = 2'(1 << w);
        @(negedge clka);
        cli.rsp_ready = 2'b00;
        check_val("idle_rsp_valid", 32'(cli.rsp_valid), 0);
        check_val("idle_busy", 32'(busy), 0);
    endtask

    task automatic reset_mid_job();
        cli.req_valid = 2'b10;
        @(posedge clka);
        @(negedge clka);
        cli.req_valid = 2'b00;
        repeat (5) @(negedge clka);
        cli.req_valid = 2'b11;
        reset_n = 1'b0;
        #1;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_eng_start", 32'(eng_start), 0);
        check_val("rst_eng_reset", 32'(eng_reset), 0);
        check_val("rst_port0", 32'(eng_port0), 0);
        check_val("rst_rsp_valid", 32'(cli.rsp_valid), 0);
        check_val("rst_req_ready", 32'(cli.req_ready), 0);
        check_val("rst_rsp_xy", 32'({cli.rsp_x, cli.rsp_y}), 0);
        cli.req_valid = 2'b00;
        repeat (2) @(negedge clka);
        reset_n = 1'b1;
        last_grant_m = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clka);
            check_val("post_rst_rsp_valid", 32'(cli.rsp_valid), 0);
            check_val("post_rst_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        cli.req_valid = '0; cli.req_mode = '0; cli.req_x = '0; cli.req_y = '0; cli.rsp_ready = '0;
        repeat (3) @(negedge clka);
        check_val("reset_busy", 32'(busy), 0);
        check_val("reset_outputs", 32'({eng_start, eng_reset, eng_mode, cli.rsp_valid, cli.rsp_err}), 0);
        check_val("reset_ports", 32'({eng_port0, eng_port1, cli.rsp_x, cli.rsp_y}), 0);
        reset_n = 1'b1;
        @(negedge clka);
        run_job(2'b01, 11, 1'b0, 0, 1'b1, 8'd10, 8'd6, 8'd0);
        for (int j = 0; j < 4; j++) run_job(2'b11, int'($urandom_range(0, 9)), 1'b0, 1, 1'b0, '0, '0, '0);
        run_job(2'b10, -1, 1'b0, 0, 1'b0, '0, '0, '0);
        run_job(2'b01, 3, 1'b0, 0, 1'b0, '0, '0, '0);
        run_job(2'b11, 5, 1'b0, 20, 1'b0, '0, '0, '0);
        run_job(2'b01, TO - 1, 1'b1, 0, 1'b0, '0, '0, '0);
        run_job(2'b10, 0, 1'b1, 0, 1'b0, '0, '0, '0);
        reset_mid_job();
        run_job(2'b11, 2, 1'b0, 0, 1'b0, '0, '0, '0);
        for (int j = 0; j < 30; j++) begin
            logic [1:0] mask;
            int         lat;
            mask = 2'($urandom_range(1, 3));
            lat  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1));
            run_job(mask, lat, 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)),
                    1'b0, '0, '0, '0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
